pass_checker_lockout: RTL and testbench
=======================================

Name: pass_checker_lockout

Overview:
- Parametrised sequential successor to the 12-bit password comparator.
- Compares an entered code against a stored code on each rising edge of `enb`.
- Holds the unlocked state for a bounded time, counts consecutive failures, and enforces a timed lockout after too many wrong attempts.
- Drives the lock actuator and the RGB status LED of the digital-lock top level.

Parameters:
- PASS_W, 12, width of entered and stored codes (>=1).
- MAX_TRIES, 3, consecutive failures that trigger lockout (>=1).
- FAIL_SHOW, 4, cycles red LED shown after a non-final failure (>=1).
- LOCKOUT_CYCLES, 20, lockout duration in cycles (>=1).
- OPEN_CYCLES, 50, cycles unlocked before automatic relock (>=1).

Ports:
- clk, input, 1, system clock, rising-edge.
- rst, input, 1, asynchronous active-high reset.
- pass_in, input, PASS_W, entered code.
- pass_set, input, PASS_W, stored code.
- enb, input, 1, submit strobe; a compare happens only on its rising edge.
- relock, input, 1, manual relock request, level-sampled.
- lock, output, 1, 1 = locked, 0 = unlocked.
- led_RGB, output, 3, {R,G,B} status.
- fail_cnt, output, $clog2(MAX_TRIES+1), consecutive failure count.
- lockout, output, 1, high while in LOCKOUT.

Behaviour:
- Single clock `clk`; reset is asynchronous and active-high on `rst`; all outputs registered.
- Reset values: state=IDLE, lock=1, led_RGB=3'b001, fail_cnt=0, lockout=0, timer=0, enb_q=1.
  - enb_q resets to 1, so `enb` held high through reset release does not submit.
- Submit: `sub = enb & ~enb_q`; enb_q <= enb every cycle.
- `sub` is acted on only in IDLE; it is ignored in all other states.
- Match: full PASS_W-bit equality of pass_in and pass_set, sampled in the sub cycle.
- Latency: outputs reflect the result on the first clock edge after the sub cycle (1 cycle).
- IDLE: lock=1, led=001.
  - sub & match -> OPEN, fail_cnt<=0, timer<=0.
  - sub & mismatch & fail_cnt==MAX_TRIES-1 -> LOCKOUT, fail_cnt<=MAX_TRIES, timer<=0.
  - sub & mismatch otherwise -> FAIL, fail_cnt+1, timer<=0.
- OPEN: lock=0, led=010; timer counts up each cycle.
  - relock=1 -> IDLE.
  - timer==OPEN_CYCLES-1 -> IDLE.
  - relock and timeout in the same cycle -> IDLE (single transition).
  - Stay time without relock: exactly OPEN_CYCLES cycles.
- FAIL: lock=1, led=100; after FAIL_SHOW cycles -> IDLE; fail_cnt retained; relock ignored.
- LOCKOUT: lock=1, led=100, lockout=1.
  - After LOCKOUT_CYCLES cycles -> IDLE, fail_cnt<=0, lockout<=0.
  - enb and relock ignored.
- fail_cnt saturates at MAX_TRIES and never wraps.
  - Cleared only by a successful match, lockout expiry, or rst.
- Timer width: $clog2 of the largest of FAIL_SHOW, LOCKOUT_CYCLES, OPEN_CYCLES, plus 1; cleared on every state entry.
- pass_set may change at any time; only its value in the sub cycle matters.
- A sub while enb stays high counts once; a new submit needs enb low for at least 1 cycle.
- rst asserted mid-OPEN, mid-FAIL or mid-LOCKOUT: immediately forces reset values, independent of clk.
- led_RGB is always exactly one-hot; 000 and multi-bit values never occur.

Test Plan (defaults, PASS_W=12):
- Reset: rst=1 for 2 cycles, then release with enb held high -> lock=1, led=001, fail_cnt=0; no submit until enb falls and rises again.
- Correct code: pass_set=1234, pass_in=1234, enb 0->1 -> next cycle lock=0, led=010; relock pulse 5 cycles later -> lock=1, led=001.
- Auto-relock: correct submit, no relock -> lock=0 for exactly 50 cycles, then lock=1, led=001.
- Wrong code: pass_set=4321, pass_in=1234, submit -> led=100 for 4 cycles, fail_cnt=1, then led=001; a second enb edge during FAIL changes nothing.
- Lockout: 3 consecutive wrong submits -> after the 3rd, lockout=1, fail_cnt=3, led=100; a correct submit during lockout is ignored; after 20 cycles lockout=0, fail_cnt=0, led=001, and a correct submit then unlocks.
- Recovery and async reset:
  - 2 wrong submits then a correct one -> unlock with fail_cnt=0.
  - Assert rst mid-LOCKOUT between clock edges -> lockout=0, lock=1, led=001 immediately.

Source files
------------

// File: rtl/pass_checker_lockout.sv
// pass_checker_lockout: sequential code checker for the digital lock.
// A rising edge on enb compares pass_in with pass_set. A match unlocks for a
// bounded time, a mismatch shows red briefly, and MAX_TRIES consecutive
// mismatches force a timed lockout. All outputs are registered.
module pass_checker_lockout #(
    parameter int PASS_W         = 12,
    parameter int MAX_TRIES      = 3,
    parameter int FAIL_SHOW      = 4,
    parameter int LOCKOUT_CYCLES = 20,
    parameter int OPEN_CYCLES    = 50
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PASS_W-1:0]              pass_in,
    input  logic [PASS_W-1:0]              pass_set,
    input  logic                           enb,
    input  logic                           relock,
    output logic                           lock,
    output logic [2:0]                     led_RGB,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
    output logic                           lockout
);

    localparam int T_MAX = (FAIL_SHOW > LOCKOUT_CYCLES)
                         ? ((FAIL_SHOW > OPEN_CYCLES) ? FAIL_SHOW : OPEN_CYCLES)
                         : ((LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES);
    localparam int TW = $clog2(T_MAX) + 1;
    localparam int CW = $clog2(MAX_TRIES + 1);

    localparam logic [TW-1:0] T_ZERO    = '0;
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LAST = TW'(FAIL_SHOW - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_TRIES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_TRIES);

    localparam logic [2:0] LED_BLUE  = 3'b001;
    localparam logic [2:0] LED_GREEN = 3'b010;
    localparam logic [2:0] LED_RED   = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_FAIL, S_LOCKOUT} state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_fail_cnt;
    logic          r_enb_q;
    logic          r_lock;
    logic [2:0]    r_led;
    logic          r_lockout;

    logic w_sub;
    logic w_match;

    // enb_q resets high so an enb held through reset release is not a submit
    assign w_sub   = enb & ~r_enb_q;
    assign w_match = (pass_in == pass_set);

    // State machine with registered outputs; every state entry clears the timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= T_ZERO;
            r_fail_cnt <= '0;
            r_enb_q    <= 1'b1;
            r_lock     <= 1'b1;
            r_led      <= LED_BLUE;
            r_lockout  <= 1'b0;
        end else begin
            r_enb_q <= enb;
            case (r_state)
                S_IDLE: begin
                    if (w_sub) begin
                        r_timer <= T_ZERO;
                        if (w_match) begin
                            r_state    <= S_OPEN;
                            r_fail_cnt <= '0;
                            r_lock     <= 1'b0;
                            r_led      <= LED_GREEN;
                        end else if (r_fail_cnt == CNT_LAST) begin
                            r_state    <= S_LOCKOUT;
                            r_fail_cnt <= CNT_MAX;
                            r_led      <= LED_RED;
                            r_lockout  <= 1'b1;
                        end else begin
                            r_state    <= S_FAIL;
                            r_fail_cnt <= r_fail_cnt + CNT_ONE;
                            r_led      <= LED_RED;
                        end
                    end
                end
                S_OPEN: begin
                    // relock and timeout together still give one transition
                    if (relock || (r_timer == OPEN_LAST)) begin
                        r_state <= S_IDLE;
                        r_timer <= T_ZERO;
                        r_lock  <= 1'b1;
                        r_led   <= LED_BLUE;
                    end else begin
                        r_timer <= r_timer + T_ONE;
                    end
                end
                S_FAIL: begin
                    if (r_timer == FAIL_LAST) begin
                        r_state <= S_IDLE;
                        r_timer <= T_ZERO;
                        r_led   <= LED_BLUE;
                    end else begin
                        r_timer <= r_timer + T_ONE;
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == LOCK_LAST) begin
                        r_state    <= S_IDLE;
                        r_timer    <= T_ZERO;
                        r_fail_cnt <= '0;
                        r_led      <= LED_BLUE;
                        r_lockout  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + T_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_timer   <= T_ZERO;
                    r_lock    <= 1'b1;
                    r_led     <= LED_BLUE;
                    r_lockout <= 1'b0;
                end
            endcase
        end
    end

    assign lock     = r_lock;
    assign led_RGB  = r_led;
    assign fail_cnt = r_fail_cnt;
    assign lockout  = r_lockout;

endmodule

// File: tb/tb_pass_checker_lockout.sv
// Bench for pass_checker_lockout: directed scenarios followed by random
// traffic, every cycle compared against a countdown-based behavioural model.
module tb_pass_checker_lockout;

    localparam int PASS_W    = 12;
    localparam int MAX_TRIES = 3;
    localparam int FAIL_SHOW = 4;
    localparam int LOCK_CYC  = 20;
    localparam int OPEN_CYC  = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [PASS_W-1:0] pass_in;
    logic [PASS_W-1:0] pass_set;
    logic              enb;
    logic              relock;
    logic              lock;
    logic [2:0]        led_RGB;
    logic [1:0]        fail_cnt;
    logic              lockout;

    pass_checker_lockout #(
        .PASS_W(PASS_W), .MAX_TRIES(MAX_TRIES), .FAIL_SHOW(FAIL_SHOW),
        .LOCKOUT_CYCLES(LOCK_CYC), .OPEN_CYCLES(OPEN_CYC)
    ) dut (
        .clk(clk), .rst(rst), .pass_in(pass_in), .pass_set(pass_set),
        .enb(enb), .relock(relock), .lock(lock), .led_RGB(led_RGB),
        .fail_cnt(fail_cnt), .lockout(lockout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=open 2=red-after-failure 3=lockout; 'left' counts
    // the cycles still to be spent in the current timed mode.
    int m_mode, m_left, m_fails;
    bit m_enbq;

    task automatic mreset();
        m_mode = 0; m_left = 0; m_fails = 0; m_enbq = 1'b1;
    endtask

    task automatic mstep();
        bit s;
        s = enb && !m_enbq;
        m_enbq = enb;
        case (m_mode)
            0: if (s) begin
                if (pass_in == pass_set) begin
                    m_mode = 1; m_left = OPEN_CYC; m_fails = 0;
                end else if (m_fails + 1 >= MAX_TRIES) begin
                    m_mode = 3; m_left = LOCK_CYC; m_fails = MAX_TRIES;
                end else begin
                    m_mode = 2; m_left = FAIL_SHOW; m_fails++;
                end
            end
            1: begin
                m_left--;
                if (relock || m_left == 0) m_mode = 0;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_mode == 3) m_fails = 0;
                    m_mode = 0;
                end
            end
        endcase
    endtask

    function automatic logic [2:0] exp_led();
        return (m_mode == 1) ? 3'b010 : (m_mode == 0) ? 3'b001 : 3'b100;
    endfunction

    task automatic check_all();
        chk("lock", lock, (m_mode != 1));
        chk("led", led_RGB, exp_led());
        chk("fail_cnt", fail_cnt, m_fails);
        chk("lockout", lockout, (m_mode == 3));
    endtask

    // One clock: model advances at the edge, DUT sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst) mreset(); else mstep();
        @(negedge clk);
        check_all();
    endtask

    task automatic submit(input logic [PASS_W-1:0] pin, input logic [PASS_W-1:0] pset);
        enb = 1'b0; tick();
        pass_in = pin; pass_set = pset; enb = 1'b1; tick();
        enb = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != 0 && n < 200) begin tick(); n++; end
        chk("wait_idle_timeout", (m_mode == 0), 1);
    endtask

    task automatic relock_pulse();
        relock = 1'b1; tick(); relock = 1'b0;
    endtask

    // Reset asserted between clock edges must take effect without a clock
    task automatic async_rst();
        #2 rst = 1'b1;
        #1;
        mreset();
        chk("arst_lock", lock, 1);
        chk("arst_led", led_RGB, 3'b001);
        chk("arst_cnt", fail_cnt, 0);
        chk("arst_lockout", lockout, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; enb = 1'b1; relock = 1'b0; pass_in = '0; pass_set = '0;
        mreset();
        tick(); tick();
        rst = 1'b0;
        // enb held high across release must not submit
        pass_in = 12'd5; pass_set = 12'd5;
        repeat (3) tick();
        chk("rst_hold_lock", lock, 1);
        chk("rst_hold_led", led_RGB, 3'b001);

        // correct code, then manual relock 5 cycles later
        submit(12'd1234, 12'd1234);
        chk("open_lock", lock, 0);
        chk("open_led", led_RGB, 3'b010);
        repeat (4) tick();
        relock_pulse();
        chk("relock_lock", lock, 1);
        chk("relock_led", led_RGB, 3'b001);

        // auto-relock: unlocked for exactly OPEN_CYC cycles
        submit(12'd1234, 12'd1234);
        cnt = 1;
        for (int i = 0; i < 200 && lock == 1'b0; i++) begin
            tick();
            if (lock == 1'b0) cnt++;
        end
        chk("open_len", cnt, OPEN_CYC);
        chk("auto_led", led_RGB, 3'b001);

        // wrong code; a second enb edge during FAIL is ignored
        submit(12'd1234, 12'd4321);
        chk("fail_led", led_RGB, 3'b100);
        chk("fail_cnt1", fail_cnt, 1);
        pass_in = 12'd4321; enb = 1'b1; tick(); enb = 1'b0;
        wait_idle();
        chk("fail_back_led", led_RGB, 3'b001);
        chk("fail_keep_cnt", fail_cnt, 1);

        // clear the count, then three wrongs in a row -> lockout
        submit(12'd4321, 12'd4321); relock_pulse(); wait_idle();
        for (int i = 0; i < MAX_TRIES; i++) begin
            submit(12'd1, 12'd4321);
            if (i < MAX_TRIES - 1) wait_idle();
        end
        chk("lockout", lockout, 1);
        chk("lock_cnt", fail_cnt, MAX_TRIES);
        chk("lock_led", led_RGB, 3'b100);
        submit(12'd4321, 12'd4321);
        chk("lock_ignore", lock, 1);
        wait_idle();
        chk("lock_exp_cnt", fail_cnt, 0);
        chk("lock_exp_out", lockout, 0);
        submit(12'd4321, 12'd4321);
        chk("post_lock_open", lock, 0);
        relock_pulse(); wait_idle();

        // two wrongs then correct clears the count
        submit(12'd7, 12'd8); wait_idle();
        submit(12'd7, 12'd8); wait_idle();
        chk("two_wrong_cnt", fail_cnt, 2);
        submit(12'd8, 12'd8);
        chk("recover_lock", lock, 0);
        chk("recover_cnt", fail_cnt, 0);
        relock_pulse(); wait_idle();

        // async reset in the middle of lockout
        for (int i = 0; i < MAX_TRIES; i++) begin
            submit(12'd9, 12'd8);
            if (i < MAX_TRIES - 1) wait_idle();
        end
        repeat (3) tick();
        chk("pre_arst_lockout", lockout, 1);
        async_rst();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) pass_set = PASS_W'($urandom);
            pass_in  = ($urandom_range(0, 1) == 1) ? pass_set : PASS_W'($urandom);
            enb      = ($urandom_range(0, 2) == 0) ? ~enb : enb;
            relock   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) async_rst();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
